maxpool_run_engine: RTL
=======================

Name: maxpool_run_engine

Overview:
- Responder on the dut_run/dut_busy handshake driven by the top-level bench.
- Reads one square signed 16-bit matrix from the input SRAM, applies 2x2 stride-2 max pooling, and writes the pooled matrix to the output SRAM.
- Serves as the post-convolution pooling stage and as the reference responder for the run/busy protocol and the synchronous-read SRAM model.

Parameters:
- ADDR_WIDTH, 12, SRAM address width.
- DATA_WIDTH, 16, SRAM word width; elements are two's-complement.
- MAX_DIM, 62, largest legal matrix dimension N (even).
- OUT_BASE, 0, output SRAM address of pooled element 0.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_b  input  1  asynchronous active-low reset.
- dut_run  input  1  job request from the bench.
- dut_busy  output  1  high while a job is in progress.
- input_sram_read_address  output  ADDR_WIDTH  input SRAM read address.
- input_sram_read_data  input  DATA_WIDTH  word for the address registered at the previous rising edge (1-cycle read latency).
- output_sram_write_enable  output  1  write strobe; the SRAM writes at the rising edge while high.
- output_sram_write_addresss  output  ADDR_WIDTH  output SRAM write address.
- output_sram_write_data  output  DATA_WIDTH  pooled value.

Behaviour:
- Reset values (immediate on reset_b low, asynchronous): dut_busy=0, output_sram_write_enable=0, all addresses=0, write_data=0, state=IDLE, all counters=0.
- Memory map:
  - Input word 0 = N, unsigned.
  - Element (r,c) is at input address 1+r*N+c, row-major.
  - Pooled element (i,j) goes to output address OUT_BASE+i*(N/2)+j.
- States: IDLE -> RD_DIM -> CHK_DIM -> POOL -> DONE -> IDLE.
- IDLE:
  - Wait for dut_run sampled high.
  - On that edge: dut_busy=1, read_address=0, go to RD_DIM.
- RD_DIM: wait one cycle for the read latency.
- CHK_DIM:
  - Capture N.
  - N legal (even, 2..MAX_DIM): go to POOL.
  - N illegal (0, odd, or >MAX_DIM): go to DONE with no SRAM writes.
- POOL:
  - For each window in raster order (i outer, j inner), issue 4 reads, one per cycle: (2i,2j), (2i,2j+1), (2i+1,2j), (2i+1,2j+1).
  - Reads are pipelined back-to-back across windows; no idle read cycles inside POOL.
  - Running max is a signed compare. The first element of each window initialises the max; it is not compared against a stale value.
  - One cycle after the 4th element's data returns, assert write_enable for exactly one cycle with that window's address and max.
  - After the last window's write cycle, go to DONE.
- DONE: dut_busy=0 next edge; go to IDLE.
- Latency:
  - dut_busy rises 1 cycle after dut_run is sampled.
  - For legal N, total busy cycles = 4*(N/2)^2 + 4, exactly.
  - For illegal N, busy lasts 3 cycles.
- Handshake rules:
  - dut_run is ignored while busy.
  - If dut_run is still high when IDLE is re-entered, a new job starts immediately, since the bench lowers run one cycle after busy rises.
  - write_enable is never high while dut_busy=0.
- Arithmetic:
  - Signed compare: 16'h8000 is the minimum, 16'h7FFF the maximum.
  - Ties keep the earlier value; the result is bit-identical either way.
  - Address arithmetic is computed in ADDR_WIDTH+1 bits; with MAX_DIM=62 the highest address is 3844, so no wrap occurs.
- Reset mid-job: the job is abandoned and no further writes occur. Output SRAM words already written remain. The engine idles until the next dut_run.

Test Plan:
- N=2, elements {3,9,-1,4} -> single write addr 0 data 0x0009; busy high 8 cycles.
- N=4, rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} -> writes addr0..3 = 6,8,14,16 in order; busy 20 cycles.
- N=2, all 16'h8000 except 16'hFFFF -> write 0xFFFF. N=2 with 0x7FFF among negatives -> write 0x7FFF (signed compare check).
- N=3, N=0, N=64 -> zero writes, busy high exactly 3 cycles, return to IDLE.
- Back-to-back: run job N=4, reload input with N=2, run again -> second job writes only addr 0 and leaves addr 1..3 from job 1 unchanged.
- Assert reset_b low mid-POOL at window 2 of N=4 -> write_enable and busy drop immediately; addr 0,1 written, addr 2,3 untouched; a fresh run then completes correctly.

Source files
------------

// File: rtl/maxpool_run_engine.sv
// 2x2 stride-2 signed max-pooling engine on the dut_run/dut_busy handshake.
// Reads an NxN matrix from a 1-cycle-latency SRAM and writes the (N/2)x(N/2) result.
module maxpool_run_engine #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_DIM    = 62,
    parameter int OUT_BASE   = 0
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  dut_run,
    output logic                  dut_busy,
    output logic [ADDR_WIDTH-1:0] input_sram_read_address,
    input  logic [DATA_WIDTH-1:0] input_sram_read_data,
    output logic                  output_sram_write_enable,
    output logic [ADDR_WIDTH-1:0] output_sram_write_addresss,
    output logic [DATA_WIDTH-1:0] output_sram_write_data
);
    localparam int AW1 = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_DIM,
        S_CHK_DIM,
        S_POOL,
        S_DONE
    } state_t;

    state_t                        r_state;
    logic [AW1-1:0]                r_n;
    logic [AW1-1:0]                r_half_m1;
    logic [AW1-1:0]                r_row_base;
    logic [AW1-1:0]                r_i;
    logic [AW1-1:0]                r_j;
    logic [1:0]                    r_rq;
    logic                          r_rd_done;
    logic [AW1-1:0]                r_oaddr;
    logic                          r_wr_last;
    logic                          r_vld_p0;
    logic                          r_vld_p1;
    logic [1:0]                    r_q_p0;
    logic [1:0]                    r_q_p1;
    logic signed [DATA_WIDTH-1:0]  r_max_p2;

    logic                          w_issue;
    logic                          w_last_elem;
    logic                          w_dim_ok;
    logic [AW1-1:0]                w_n_in;
    logic [AW1-1:0]                w_rd_addr;
    logic signed [DATA_WIDTH-1:0]  w_data;
    logic signed [DATA_WIDTH-1:0]  w_max_next;

    // Signed maximum; on a tie the earlier operand a is kept.
    function automatic logic signed [DATA_WIDTH-1:0] f_smax(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        return (b > a) ? b : a;
    endfunction

    // Saturate an extended address into the SRAM address range.
    function automatic logic [ADDR_WIDTH-1:0] f_sat_addr(input logic [AW1-1:0] a);
        return a[AW1-1] ? {ADDR_WIDTH{1'b1}} : a[ADDR_WIDTH-1:0];
    endfunction

    assign w_n_in   = AW1'(input_sram_read_data);
    assign w_dim_ok = (input_sram_read_data[0] == 1'b0) &&
                      (input_sram_read_data != '0) &&
                      (input_sram_read_data <= DATA_WIDTH'(MAX_DIM));

    // The first two reads of window 0 do not depend on N, so they overlap the
    // dimension fetch and the stream stays back-to-back from RD_DIM onwards.
    assign w_issue = (r_state == S_RD_DIM) || (r_state == S_CHK_DIM) ||
                     ((r_state == S_POOL) && !r_rd_done);

    assign w_rd_addr = r_row_base + (r_rq[1] ? r_n : '0) +
                       {r_j[AW1-2:0], 1'b0} + AW1'(r_rq[0]);

    assign w_last_elem = (r_rq == 2'd3) && (r_i == r_half_m1) && (r_j == r_half_m1);

    assign w_data     = input_sram_read_data;
    assign w_max_next = (r_q_p1 == 2'd0) ? w_data : f_smax(r_max_p2, w_data);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state                    <= S_IDLE;
            dut_busy                   <= 1'b0;
            input_sram_read_address    <= '0;
            output_sram_write_enable   <= 1'b0;
            output_sram_write_addresss <= '0;
            output_sram_write_data     <= '0;
            r_n                        <= '0;
            r_half_m1                  <= '0;
            r_row_base                 <= '0;
            r_i                        <= '0;
            r_j                        <= '0;
            r_rq                       <= '0;
            r_rd_done                  <= 1'b0;
            r_oaddr                    <= '0;
            r_wr_last                  <= 1'b0;
            r_vld_p0                   <= 1'b0;
            r_vld_p1                   <= 1'b0;
            r_q_p0                     <= '0;
            r_q_p1                     <= '0;
            r_max_p2                   <= '0;
        end else begin
            // Stage p0: read address issue and raster-order window walk
            r_vld_p0 <= w_issue;
            if (w_issue) begin
                input_sram_read_address <= f_sat_addr(w_rd_addr);
                r_q_p0                  <= r_rq;
                r_rq                    <= r_rq + 2'd1;
                if (r_rq == 2'd3) begin
                    if (r_j == r_half_m1) begin
                        r_j        <= '0;
                        r_i        <= r_i + AW1'(1);
                        r_row_base <= r_row_base + {r_n[AW1-2:0], 1'b0};
                    end else begin
                        r_j <= r_j + AW1'(1);
                    end
                end
                if (w_last_elem) begin
                    r_rd_done <= 1'b1;
                end
            end

            // Stage p1: SRAM latency, data for the p0 address is on the bus next
            r_vld_p1 <= r_vld_p0;
            r_q_p1   <= r_q_p0;

            // Stage p2: running max and registered write strobe
            output_sram_write_enable <= 1'b0;
            if (r_vld_p1) begin
                r_max_p2 <= w_max_next;
                if (r_q_p1 == 2'd3) begin
                    output_sram_write_enable   <= 1'b1;
                    output_sram_write_addresss <= f_sat_addr(r_oaddr);
                    output_sram_write_data     <= w_max_next;
                    r_oaddr                    <= r_oaddr + AW1'(1);
                    r_wr_last                  <= !r_vld_p0;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (dut_run) begin
                        dut_busy                <= 1'b1;
                        input_sram_read_address <= '0;
                        r_row_base              <= AW1'(1);
                        r_i                     <= '0;
                        r_j                     <= '0;
                        r_rq                    <= '0;
                        r_rd_done               <= 1'b0;
                        r_oaddr                 <= AW1'(OUT_BASE);
                        r_state                 <= S_RD_DIM;
                    end
                end
                S_RD_DIM: begin
                    r_state <= S_CHK_DIM;
                end
                S_CHK_DIM: begin
                    r_n       <= w_n_in;
                    r_half_m1 <= (w_n_in >> 1) - AW1'(1);
                    r_state   <= w_dim_ok ? S_POOL : S_DONE;
                end
                S_POOL: begin
                    if (output_sram_write_enable && r_wr_last) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    dut_busy <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
